// File: rtl/dds_sweep_ctrl_pkg.sv
// dds_pkg: shared types and default widths for the DDS sweep controller.
package dds_pkg;
    localparam int FW_W_DEF = 8;
    localparam int PW_W_DEF = 9;
    localparam int DWELL_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: sweep request inputs and DDS word outputs of the sweep controller.
interface dds_sweep_ctrl_if
    import dds_pkg::*;
#(
    parameter int FW_W = FW_W_DEF,
    parameter int PW_W = PW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
);
    logic start;
    logic abort;
    logic hold;
    logic mode;
    logic [FW_W-1:0] f_start;
    logic [FW_W-1:0] f_stop;
    logic [FW_W-1:0] f_step;
    logic [DWELL_W-1:0] dwell;
    logic [PW_W-1:0] p_offset;
    logic [FW_W-1:0] Fword;
    logic [PW_W-1:0] Pword1;
    logic [PW_W-1:0] Pword2;
    logic DDS_rst;
    logic busy;
    logic step_stb;
    logic done;
    modport master (
        output start, abort, hold, mode, f_start, f_stop, f_step, dwell, p_offset,
        input Fword, Pword1, Pword2, DDS_rst, busy, step_stb, done
    );
    modport slave (
        input start, abort, hold, mode, f_start, f_stop, f_step, dwell, p_offset,
        output Fword, Pword1, Pword2, DDS_rst, busy, step_stb, done
    );
endinterface

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// dds_dwell_timer: loadable down-counter; load wins over enable, zero flags an expired dwell.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int W = DWELL_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    input  logic [W-1:0] load_val,
    output logic zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else cnt <= load ? load_val : en ? cnt - W'(1) : cnt;
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS frequency word linearly from f_start to f_stop,
// holding each value for dwell+1 run cycles, with DDS_rst on every (re)start.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW_W = FW_W_DEF,
    parameter int PW_W = PW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input logic clk,
    input logic reset,
    dds_sweep_ctrl_if.slave bus
);
    state_t state, state_d;
    logic [FW_W-1:0] f_start_q, f_stop_q, f_step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic mode_q, dir_q;
    logic [FW_W-1:0] fword_q, fword_d;
    logic [PW_W-1:0] pword1_q, pword1_d, pword2_q, pword2_d;
    logic dds_rst_q, dds_rst_d, busy_q, busy_d, step_stb_q, step_stb_d, done_q, done_d;
    logic capture, load, en, zero;
    logic [DWELL_W-1:0] load_val;
    logic [FW_W-1:0] step_eff, down_gap, next_fw;
    logic [FW_W:0] up_sum;

    dds_dwell_timer #(.W(DWELL_W)) u_timer (
        .clk(clk), .reset(reset), .load(load), .en(en), .load_val(load_val), .zero(zero)
    );

    // Up steps use one extra bit so a wrap past the top reads as overshoot; down steps compare
    // the step against the remaining gap so they can never underflow.
    assign step_eff = (f_step_q == '0) ? FW_W'(1) : f_step_q;
    assign up_sum = {1'b0, fword_q} + {1'b0, step_eff};
    assign down_gap = fword_q - f_stop_q;
    assign next_fw = (dir_q == DIR_UP) ? ((up_sum >= {1'b0, f_stop_q}) ? f_stop_q : up_sum[FW_W-1:0])
                                       : ((step_eff >= down_gap) ? f_stop_q : fword_q - step_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            fword_q <= '0;
            pword1_q <= '0;
            pword2_q <= '0;
            dds_rst_q <= 1'b0;
            busy_q <= 1'b0;
            step_stb_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state <= state_d;
            fword_q <= fword_d;
            pword1_q <= pword1_d;
            pword2_q <= pword2_d;
            dds_rst_q <= dds_rst_d;
            busy_q <= busy_d;
            step_stb_q <= step_stb_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_start_q <= '0;
            f_stop_q <= '0;
            f_step_q <= '0;
            dwell_q <= '0;
            mode_q <= 1'b0;
            dir_q <= DIR_UP;
        end else if (capture) begin
            f_start_q <= bus.f_start;
            f_stop_q <= bus.f_stop;
            f_step_q <= bus.f_step;
            dwell_q <= bus.dwell;
            mode_q <= bus.mode;
            dir_q <= (bus.f_stop >= bus.f_start) ? DIR_UP : DIR_DOWN;
        end
    end

    // A RUN cycle always does its count/step work; hold only decides whether the next cycle pauses.
    always_comb begin
        state_d = state;
        fword_d = fword_q;
        pword1_d = pword1_q;
        pword2_d = pword2_q;
        dds_rst_d = 1'b0;
        busy_d = busy_q;
        step_stb_d = 1'b0;
        done_d = 1'b0;
        capture = 1'b0;
        load = 1'b0;
        load_val = dwell_q;
        en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    capture = 1'b1;
                    load = 1'b1;
                    load_val = bus.dwell;
                    fword_d = bus.f_start;
                    pword1_d = '0;
                    pword2_d = bus.p_offset;
                    dds_rst_d = 1'b1;
                    busy_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    busy_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = bus.hold ? PAUSE : RUN;
                    if (!zero) begin
                        en = 1'b1;
                    end else if (fword_q != f_stop_q) begin
                        fword_d = next_fw;
                        load = 1'b1;
                        step_stb_d = 1'b1;
                    end else if (mode_q) begin
                        fword_d = f_start_q;
                        dds_rst_d = 1'b1;
                        load = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            PAUSE: begin
                busy_d = !bus.abort;
                state_d = bus.abort ? IDLE : bus.hold ? PAUSE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Fword = fword_q;
    assign bus.Pword1 = pword1_q;
    assign bus.Pword2 = pword2_q;
    assign bus.DDS_rst = dds_rst_q;
    assign bus.busy = busy_q;
    assign bus.step_stb = step_stb_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: table of sweep cases expanded into per-cycle expectations on a scoreboard,
// plus hand sequences for continuous mode, hold/abort and asynchronous reset.
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    typedef struct packed {
        logic [7:0] fw;
        logic [8:0] p1;
        logic [8:0] p2;
        logic rst;
        logic busy;
        logic stb;
        logic done;
    } obs_t;

    typedef struct {
        logic [7:0] fs;
        logic [7:0] fe;
        logic [7:0] st;
        logic [15:0] dw;
        logic [8:0] po;
        int n;
        logic [7:0] v [4];
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    obs_t q[$];
    vec_t tbl[6];
    int checks = 0;
    int errors = 0;

    dds_sweep_ctrl_if bus ();
    dds_sweep_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic obs_t sample();
        return {bus.Fword, bus.Pword1, bus.Pword2, bus.DDS_rst, bus.busy, bus.step_stb, bus.done};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got fw=%0d p1=%0d p2=%0d rst=%b busy=%b stb=%b done=%b, expected fw=%0d p1=%0d p2=%0d rst=%b busy=%b stb=%b done=%b",
                     name, got.fw, got.p1, got.p2, got.rst, got.busy, got.stb, got.done,
                     exp.fw, exp.p1, exp.p2, exp.rst, exp.busy, exp.stb, exp.done);
        end
    endtask

    task automatic push(input logic [7:0] fw, input logic [8:0] p2, input logic rst,
                        input logic busy, input logic stb, input logic done);
        q.push_back({fw, 9'd0, p2, rst, busy, stb, done});
    endtask

    task automatic pop_check(input string name);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got fw=%0d", name, bus.Fword);
        end else begin
            check(name, sample(), q.pop_front());
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.hold = 1'b0;
        bus.mode = 1'b0;
    endtask

    task automatic set_row(input int i, input logic [7:0] fs, input logic [7:0] fe, input logic [7:0] st,
                           input logic [15:0] dw, input logic [8:0] po, input int n,
                           input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
        tbl[i].fs = fs;
        tbl[i].fe = fe;
        tbl[i].st = st;
        tbl[i].dw = dw;
        tbl[i].po = po;
        tbl[i].n = n;
        tbl[i].v[0] = v0;
        tbl[i].v[1] = v1;
        tbl[i].v[2] = v2;
        tbl[i].v[3] = v3;
    endtask

    task automatic run_row(input int i);
        vec_t r;
        r = tbl[i];
        for (int k = 0; k < r.n; k++)
            for (int c = 0; c <= int'(r.dw); c++)
                push(r.v[k], r.po, k == 0 && c == 0, 1'b1, k > 0 && c == 0, 1'b0);
        push(r.v[r.n-1], r.po, 1'b0, 1'b0, 1'b0, 1'b1);
        push(r.v[r.n-1], r.po, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.f_start = r.fs;
        bus.f_stop = r.fe;
        bus.f_step = r.st;
        bus.dwell = r.dw;
        bus.p_offset = r.po;
        bus.mode = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        pop_check($sformatf("row%0d_first", i));
        bus.start = 1'b0;
        bus.f_start = ~r.fs;
        bus.f_stop = ~r.fe;
        bus.f_step = r.st + 8'd1;
        bus.dwell = r.dw + 16'd3;
        bus.p_offset = ~r.po;
        bus.mode = 1'b1;
        while (q.size() > 0) begin
            @(negedge clk);
            pop_check($sformatf("row%0d_cyc", i));
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus.f_start = '0;
        bus.f_stop = '0;
        bus.f_step = '0;
        bus.dwell = '0;
        bus.p_offset = '0;
        set_row(0, 8'd10, 8'd16, 8'd3, 16'd2, 9'd0, 3, 8'd10, 8'd13, 8'd16, 8'd0);
        set_row(1, 8'd20, 8'd5, 8'd7, 16'd0, 9'd45, 4, 8'd20, 8'd13, 8'd6, 8'd5);
        set_row(2, 8'd3, 8'd5, 8'd0, 16'd1, 9'd100, 3, 8'd3, 8'd4, 8'd5, 8'd0);
        set_row(3, 8'd9, 8'd9, 8'd5, 16'd1, 9'd256, 1, 8'd9, 8'd0, 8'd0, 8'd0);
        set_row(4, 8'd0, 8'd255, 8'd100, 16'd0, 9'h1FF, 4, 8'd0, 8'd100, 8'd200, 8'd255);
        set_row(5, 8'd255, 8'd0, 8'd200, 16'd0, 9'd1, 3, 8'd255, 8'd55, 8'd0, 8'd0);

        #1 reset = 1'b1;
        #1 check("reset_async", sample(), obs_t'(0));
        repeat (2) @(negedge clk);
        check("reset_held", sample(), obs_t'(0));
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_row(i);

        // Continuous 4->6: restart pulses DDS_rst, a mid-sweep start is ignored, then abort and start+abort.
        for (int i = 0; i < 9; i++)
            push(((i / 2) % 2) != 0 ? 8'd6 : 8'd4, 9'd33, (i % 4) == 0, 1'b1, (i % 4) == 2, 1'b0);
        repeat (3) push(8'd4, 9'd33, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.f_start = 8'd4;
        bus.f_stop = 8'd6;
        bus.f_step = 8'd2;
        bus.dwell = 16'd1;
        bus.p_offset = 9'd33;
        bus.mode = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pop_check($sformatf("cont%0d", i));
            if (i == 0) bus.start = 1'b0;
            if (i == 1) begin bus.start = 1'b1; bus.f_start = 8'd8; end
            if (i == 2) bus.start = 1'b0;
            if (i == 8) bus.abort = 1'b1;
            if (i == 9) bus.start = 1'b1;
            if (i == 10) begin bus.start = 1'b0; bus.abort = 1'b0; end
        end
        idle_inputs();

        // 10->16 with hold for five cycles in the first dwell, abort in the second dwell.
        push(8'd10, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (7) push(8'd10, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(8'd13, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        push(8'd13, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) push(8'd13, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.f_start = 8'd10;
        bus.f_stop = 8'd16;
        bus.f_step = 8'd3;
        bus.dwell = 16'd2;
        bus.p_offset = 9'd0;
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pop_check($sformatf("hold%0d", i));
            if (i == 0) begin bus.start = 1'b0; bus.hold = 1'b1; end
            if (i == 5) bus.hold = 1'b0;
            if (i == 9) bus.abort = 1'b1;
            if (i == 10) bus.abort = 1'b0;
        end
        idle_inputs();

        // Asynchronous reset in the middle of a continuous sweep, then a fresh sweep.
        push(8'd0, 9'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) push(8'd0, 9'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        push(8'd1, 9'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus.f_start = 8'd0;
        bus.f_stop = 8'd255;
        bus.f_step = 8'd1;
        bus.dwell = 16'd3;
        bus.p_offset = 9'd7;
        bus.mode = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pop_check($sformatf("pre_reset%0d", i));
            bus.start = 1'b0;
        end
        #2 reset = 1'b1;
        #1 check("mid_reset_async", sample(), obs_t'(0));
        @(negedge clk);
        check("mid_reset_held", sample(), obs_t'(0));
        reset = 1'b0;
        idle_inputs();
        run_row(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the DDS frequency/phase words for a linear frequency sweep, replacing manual keypad entry when a sweep is requested. It steps a frequency word from f_start to f_stop in increments of f_step, holding each value for a programmable dwell. It supplies a fixed phase offset between the two DDS channels and pulses DDS_rst on every sweep (re)start so both accumulators align. Sits between the control/keypad front end and the DDS core, in parallel with the manual frequency/phase register path.

Parameters:
FW_W, 8, frequency word width
PW_W, 9, phase word width
DWELL_W, 16, dwell counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; begins sweep from IDLE
abort  in  1  1-cycle pulse; ends sweep immediately
hold  in  1  level; freezes dwell countdown while high
mode  in  1  0 = single sweep, 1 = continuous (restart at f_start)
f_start  in  FW_W  first frequency word
f_stop  in  FW_W  final frequency word (below f_start = downward sweep)
f_step  in  FW_W  step magnitude (0 treated as 1)
dwell  in  DWELL_W  Fword held dwell+1 cycles per value
p_offset  in  PW_W  channel-2 phase offset
Fword  out  FW_W  frequency word to DDS
Pword1  out  PW_W  channel-1 phase word
Pword2  out  PW_W  channel-2 phase word
DDS_rst  out  1  1-cycle accumulator reset pulse
busy  out  1  high in RUN or PAUSE
step_stb  out  1  1-cycle pulse when Fword changes mid-sweep
done  out  1  1-cycle pulse at end of single sweep

Behaviour:
- Reset (async): state IDLE; Fword, Pword1, Pword2, counter = 0; DDS_rst, busy, step_stb, done = 0.
- All outputs registered. DDS_rst, step_stb, done are single-cycle pulses.
- States: IDLE, RUN, PAUSE.
- IDLE + start: at that edge, capture f_start/f_stop/f_step/mode/p_offset/dwell into shadow registers; Fword<=f_start, Pword1<=0, Pword2<=p_offset, DDS_rst<=1, busy<=1, cnt<=dwell; go to RUN. Input changes during the sweep have no effect.
- Direction is fixed at capture: up if f_stop >= f_start, else down.
- RUN: if cnt != 0, decrement. If cnt == 0 (expiry):
  - Fword != f_stop: advance; reload cnt; step_stb<=1.
  - Up: next = Fword + step, computed in FW_W+1 bits, clamped to f_stop if >= f_stop.
  - Down: next = f_stop if Fword - step <= f_stop (no underflow), else Fword - step.
  - Fword == f_stop and mode=1: Fword<=f_start, DDS_rst<=1, reload cnt; stay in RUN.
  - Fword == f_stop and mode=0: done<=1, busy<=0, go to IDLE. Fword holds f_stop.
- Hold: RUN + hold goes to PAUSE. Counter and outputs freeze. PAUSE + !hold returns to RUN, resuming the remaining count.
- Every Fword value is present for exactly dwell+1 RUN cycles, excluding PAUSE cycles.
- Abort: in RUN or PAUSE, go to IDLE next edge; busy<=0; no done. Fword and Pwords keep their current values. Abort beats expiry and hold on the same cycle. Abort in IDLE is ignored.
- Start while busy is ignored. Start and abort together in IDLE: abort wins (stay IDLE).
- f_start == f_stop: one dwell, then end/restart.
- f_step = 0 is treated as 1.
- Reset mid-sweep: immediate return to reset values.

Decomposition:
- Package dds_pkg: state enum (IDLE/RUN/PAUSE), FW_W/PW_W/DWELL_W defaults, direction constants.
- Sub-module dds_dwell_timer: loadable down-counter with load/enable inputs and a zero flag.
- Step arithmetic, clamping and the FSM stay in the top level.

Test Plan:
- Up sweep, start at edge t0, f_start=10, f_stop=16, f_step=3, dwell=2, mode=0 -> Fword 10 for t0..t0+2, 13 from t0+3, 16 from t0+6; step_stb at t0+3 and t0+6; done one cycle after edge t0+9, busy low; DDS_rst only after t0.
- Down sweep, 20->5, step=7, dwell=0 -> Fword 20, 13, 6, 5 on consecutive cycles (clamp to 5); done after 4 values.
- Continuous mode, 4->6, step=2, dwell=1 -> 4, 4, 6, 6, 4 ...; DDS_rst pulses at each return to 4; done never asserts.
- hold high 5 cycles mid-dwell, then abort in the 2nd dwell of the 10->16 case -> Fword frozen during hold, dwell resumes after; abort gives busy=0 next cycle, Fword stays 13, no done.
- Edge cases: f_step=0 with 3->5 -> steps of 1; f_start==f_stop=9 -> one dwell then done; start while busy ignored; start+abort in IDLE stays idle.
- Assert reset mid-sweep asynchronously -> all outputs 0 without a clock edge; a fresh start sweeps normally.
